pwm_ramp_ctrl: RTL and testbench

Sequencing controller for the 3-bit PWM generator. It enables the generator, loads an initial duty cycle, and then slews the duty toward a requested target. Slewing uses single-cycle increment/decrement pulses at a programmable rate. On stop it ramps the duty down to zero before disabling the generator. The block sits between the host/configuration logic and the PWM generator, and owns all of the generator's control inputs.

---
 rtl/pwm_ramp_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequencing controller for a PWM generator.
// It enables the generator, loads an initial duty, slews the duty toward a
// requested target with single-cycle inc/dec pulses every STEP_DIV clocks,
// and on stop ramps the duty down to zero before disabling the generator.
// Every output is driven straight from a register.
module pwm_ramp_ctrl #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned STEP_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] init_duty,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_duty,
    output logic             tgt_ready,
    output logic             pwm_en,
    output logic             pwm_load,
    output logic [WIDTH-1:0] pwm_duty,
    output logic             pwm_inc,
    output logic             pwm_dec,
    output logic [WIDTH-1:0] cur_duty,
    output logic             busy
);

    // Step counter runs 0..STEP_DIV-1; a one-cycle divider still needs one bit.
    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RAMP,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_duty;
    logic             r_en;
    logic             r_load;
    logic             r_inc;
    logic             r_dec;
    logic             r_ready;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_tgt_nxt;
    logic [WIDTH-1:0] w_cur_nxt;
    logic [WIDTH-1:0] w_duty_nxt;
    logic             w_inc_nxt;
    logic             w_dec_nxt;
    logic             w_hs;
    logic             w_wrap;
    logic [WIDTH-1:0] w_step_tgt;
    logic             w_up;
    logic             w_need;
    logic [WIDTH-1:0] w_cur_step;
    logic             w_en_nxt;
    logic             w_busy_nxt;
    logic             w_ready_nxt;

    // Handshake is qualified by the registered ready, which is only high in HOLD.
    assign w_hs       = tgt_valid & r_ready;
    assign w_wrap     = (r_cnt == CNT_LAST);
    // While draining the effective target is zero regardless of the latched one.
    assign w_step_tgt = (r_state == S_DRAIN) ? '0 : r_tgt;
    assign w_up       = (w_step_tgt > r_cur);
    assign w_need     = (w_step_tgt != r_cur);
    // Only used when w_need is true, so cur never steps past 0 or the maximum.
    assign w_cur_step = w_up ? (r_cur + WIDTH'(1)) : (r_cur - WIDTH'(1));

    // Next-state, datapath and pulse decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_tgt_nxt   = r_tgt;
        w_cur_nxt   = r_cur;
        w_duty_nxt  = r_duty;
        w_inc_nxt   = 1'b0;
        w_dec_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // stop has priority over start
                if (start && !stop) begin
                    w_state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                w_duty_nxt  = init_duty;
                w_cur_nxt   = init_duty;
                w_state_nxt = stop ? S_DRAIN : S_HOLD;
            end

            S_HOLD: begin
                // stop wins over a same-cycle handshake; that target is dropped
                if (stop) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_hs) begin
                    w_tgt_nxt = tgt_duty;
                    if (tgt_duty != r_cur) begin
                        w_state_nxt = S_RAMP;
                    end
                end
            end

            S_RAMP, S_DRAIN: begin
                if (r_state == S_DRAIN) begin
                    w_tgt_nxt = '0;
                end
                if ((r_state == S_DRAIN) && (r_cur == '0)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    // Counter keeps running across RAMP->DRAIN so step spacing holds.
                    w_cnt_nxt = w_wrap ? '0 : (r_cnt + CNT_W'(1));
                    if (w_wrap && w_need) begin
                        w_cur_nxt = w_cur_step;
                        if (w_up) begin
                            w_inc_nxt = 1'b1;
                        end else begin
                            w_dec_nxt = 1'b1;
                        end
                        if ((r_state == S_RAMP) && (w_cur_step == r_tgt)) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                    if ((r_state == S_RAMP) && stop) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs derived from the upcoming state so they line up with it.
    always_comb begin
        w_en_nxt    = (w_state_nxt == S_HOLD) || (w_state_nxt == S_RAMP) ||
                      (w_state_nxt == S_DRAIN);
        w_busy_nxt  = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RAMP) ||
                      (w_state_nxt == S_DRAIN);
        // Ready rises one cycle after HOLD is entered and drops as HOLD is left.
        w_ready_nxt = (r_state == S_HOLD) && (w_state_nxt == S_HOLD);
    end

    // State, counter and latched target.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    // Registered generator controls and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cur   <= '0;
            r_duty  <= '0;
            r_en    <= 1'b0;
            r_load  <= 1'b0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_cur   <= w_cur_nxt;
            r_duty  <= w_duty_nxt;
            r_en    <= w_en_nxt;
            r_load  <= (r_state == S_LOAD);
            r_inc   <= w_inc_nxt;
            r_dec   <= w_dec_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign tgt_ready = r_ready;
    assign pwm_en    = r_en;
    assign pwm_load  = r_load;
    assign pwm_duty  = r_duty;
    assign pwm_inc   = r_inc;
    assign pwm_dec   = r_dec;
    assign cur_duty  = r_cur;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl. Instance u_dut4 (STEP_DIV=4) is checked by an
// event scoreboard with hand-computed cycle numbers; instance u_dut1
// (STEP_DIV=1) is driven with random targets and checked against a
// generator model.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_start, a_stop, a_valid;
    logic [2:0] a_init, a_tgt;
    logic       a_ready, a_en, a_load, a_inc, a_dec, a_busy;
    logic [2:0] a_duty, a_cur;

    logic       b_start, b_stop, b_valid;
    logic [2:0] b_init, b_tgt;
    logic       b_ready, b_en, b_load, b_inc, b_dec, b_busy;
    logic [2:0] b_duty, b_cur;

    pwm_ramp_ctrl #(.WIDTH(3), .STEP_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(a_start), .stop(a_stop),
        .init_duty(a_init), .tgt_valid(a_valid), .tgt_duty(a_tgt),
        .tgt_ready(a_ready), .pwm_en(a_en), .pwm_load(a_load),
        .pwm_duty(a_duty), .pwm_inc(a_inc), .pwm_dec(a_dec),
        .cur_duty(a_cur), .busy(a_busy)
    );

    pwm_ramp_ctrl #(.WIDTH(3), .STEP_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop),
        .init_duty(b_init), .tgt_valid(b_valid), .tgt_duty(b_tgt),
        .tgt_ready(b_ready), .pwm_en(b_en), .pwm_load(b_load),
        .pwm_duty(b_duty), .pwm_inc(b_inc), .pwm_dec(b_dec),
        .cur_duty(b_cur), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_LOAD, EV_INC, EV_DEC, EV_READY, EV_OFF} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         cyc;
        logic [2:0] cur;
    } ev_t;
    ev_t exp_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push(input ev_kind_t k, input int c, input int cur);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.cur  = 3'(cur);
        exp_q.push_back(e);
    endfunction

    task automatic mon_event(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d want none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", k, e.kind);
            check("ev_cycle", cyc, e.cyc);
            check("ev_cur_duty", a_cur, e.cur);
            if (k == EV_LOAD) begin
                check("load_pwm_duty", a_duty, e.cur);
                check("load_pwm_en", a_en, 1);
            end
        end
    endtask

    // Scoreboard monitor for u_dut4: every visible output event pops one expectation.
    logic a_ready_q = 1'b0;
    logic a_en_q    = 1'b0;
    always @(negedge clk) begin
        check("a_inc_dec_excl", a_inc & a_dec, 0);
        if (a_load)               mon_event(EV_LOAD);
        if (a_inc)                mon_event(EV_INC);
        if (a_dec)                mon_event(EV_DEC);
        if (a_ready && !a_ready_q) mon_event(EV_READY);
        if (!a_en && a_en_q)      mon_event(EV_OFF);
        a_ready_q = a_ready;
        a_en_q    = a_en;
    end

    // Generator model for u_dut1: gen_b is the duty the generator holds after the next edge.
    bit         b_mon_on = 1'b0;
    logic [2:0] gen_b    = '0;
    always @(negedge clk) begin
        logic [2:0] nxt;
        if (b_mon_on) begin
            check("b_inc_dec_excl", b_inc & b_dec, 0);
            check("b_ready_while_busy", b_ready & b_busy, 0);
            if (b_load)     nxt = b_duty;
            else if (b_inc) nxt = gen_b + 3'd1;
            else if (b_dec) nxt = gen_b - 3'd1;
            else            nxt = gen_b;
            if (b_en) check("b_cur_vs_gen", b_cur, nxt);
            gen_b = nxt;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_tgt_ready"}, a_ready, 0);
        check({tag, "_pwm_en"},    a_en,    0);
        check({tag, "_pwm_load"},  a_load,  0);
        check({tag, "_pwm_duty"},  a_duty,  0);
        check({tag, "_pwm_inc"},   a_inc,   0);
        check({tag, "_pwm_dec"},   a_dec,   0);
        check({tag, "_cur_duty"},  a_cur,   0);
        check({tag, "_busy"},      a_busy,  0);
    endtask

    // Offer a target to u_dut4; hs returns the edge that accepted it.
    task automatic send_a(input logic [2:0] t, output int hs);
        bit done = 1'b0;
        hs      = -1;
        a_tgt   = t;
        a_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (a_ready === 1'b1) begin
                hs   = cyc + 1;
                done = 1'b1;
            end
            tick();
        end
        a_valid = 1'b0;
        check("a_handshake_timeout", done, 1);
    endtask

    task automatic wait_a_ready();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (a_ready === 1'b1) done = 1'b1;
            else tick();
        end
        check("a_ready_timeout", done, 1);
    endtask

    task automatic send_b(input logic [2:0] t);
        bit done = 1'b0;
        b_tgt   = t;
        b_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (b_ready === 1'b1) done = 1'b1;
            tick();
        end
        b_valid = 1'b0;
        check("b_handshake_timeout", done, 1);
    endtask

    task automatic wait_b_ready();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (b_ready === 1'b1) done = 1'b1;
            else tick();
        end
        check("b_ready_timeout", done, 1);
    endtask

    initial begin
        int hs;
        int k;
        logic [2:0] t;
        bit off;

        rst = 1'b0;
        a_start = 0; a_stop = 0; a_valid = 0; a_init = '0; a_tgt = '0;
        b_start = 0; b_stop = 0; b_valid = 0; b_init = '0; b_tgt = '0;
        tick(3);
        check_a_zero("reset");
        rst = 1'b1;
        tick(2);
        check("idle_after_reset_en", a_en, 0);
        b_mon_on = 1'b1;

        // start with init_duty=3
        a_init  = 3'd3;
        a_start = 1'b1;
        k = cyc + 1;
        push(EV_LOAD, k + 1, 3);
        push(EV_READY, k + 2, 3);
        tick();
        a_start = 1'b0;
        tick(3);

        // 3 -> 2: one decrement
        send_a(3'd2, hs);
        check("ramp_busy", a_busy, 1);
        check("ramp_ready_low", a_ready, 0);
        push(EV_DEC, hs + 4, 2);
        push(EV_READY, hs + 5, 2);

        // 2 -> 6: four increments, 4 cycles apart
        send_a(3'd6, hs);
        for (int i = 1; i <= 4; i++) push(EV_INC, hs + 4 * i, 2 + i);
        push(EV_READY, hs + 17, 6);

        // 6 -> 7 (upper bound)
        send_a(3'd7, hs);
        push(EV_INC, hs + 4, 7);
        push(EV_READY, hs + 5, 7);

        // 7 -> 0: seven decrements
        send_a(3'd0, hs);
        for (int i = 1; i <= 7; i++) push(EV_DEC, hs + 4 * i, 7 - i);
        push(EV_READY, hs + 29, 0);

        // target equal to cur_duty: no pulse, ready stays high
        send_a(3'd0, hs);
        for (int i = 0; i < 6; i++) begin
            check("noop_ready_high", a_ready, 1);
            check("noop_cur", a_cur, 0);
            tick();
        end

        // 0 -> 5, then stop drains 5 -> 0
        send_a(3'd5, hs);
        for (int i = 1; i <= 5; i++) push(EV_INC, hs + 4 * i, i);
        push(EV_READY, hs + 21, 5);
        wait_a_ready();
        a_stop = 1'b1;
        k = cyc + 1;
        for (int i = 1; i <= 5; i++) push(EV_DEC, k + 4 * i, 5 - i);
        push(EV_OFF, k + 21, 0);
        tick(24);
        check("drain_en_off", a_en, 0);
        check("drain_cur_zero", a_cur, 0);

        // start and stop together in IDLE: stays idle
        a_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("start_stop_en", a_en, 0);
            check("start_stop_busy", a_busy, 0);
        end
        a_start = 1'b0;
        a_stop  = 1'b0;
        tick(2);

        // reset in the middle of a ramp
        a_init  = 3'd1;
        a_start = 1'b1;
        k = cyc + 1;
        push(EV_LOAD, k + 1, 1);
        push(EV_READY, k + 2, 1);
        tick();
        a_start = 1'b0;
        send_a(3'd7, hs);
        push(EV_INC, hs + 4, 2);
        push(EV_INC, hs + 8, 3);
        push(EV_OFF, hs + 10, 0);
        tick(9);
        rst = 1'b0;
        tick();
        check_a_zero("midramp_reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_idle_en", a_en, 0);
            check("post_reset_idle_busy", a_busy, 0);
            check("post_reset_idle_ready", a_ready, 0);
        end

        // STEP_DIV=1 instance: random targets against the generator model
        b_init  = 3'd4;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int j = 0; j < 14; j++) begin
            t = 3'($urandom_range(0, 7));
            send_b(t);
            wait_b_ready();
            check("b_target_reached", b_cur, t);
        end
        b_stop = 1'b1;
        off = 1'b0;
        for (int i = 0; i < 40 && !off; i++) begin
            tick();
            if (b_en === 1'b0) off = 1'b1;
        end
        check("b_stop_disables", off, 1);
        check("b_stop_cur_zero", b_cur, 0);
        b_stop = 1'b0;

        // every expected event must have been seen
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
